// File: rtl/bp_counter_table_if.sv
// ============================================================================
//  Module      : bp_counter_table_if
//  Description : Bundle of lookup, prediction and training signals between
//                the fetch / branch-resolve logic and the pattern-history
//                table.
//                master modport : fetch + resolve side (drives requests)
//                slave  modport : bp_counter_table (returns predictions)
//  Signals     : lookup_en/lookup_pc           lookup request
//                pred_valid/taken/cnt/hist     registered prediction
//                upd_valid/pc/hist/taken       training request
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bp_counter_table_if #(
    parameter int PC_W   = 64,
    parameter int CNT_W  = 2,
    parameter int HIST_W = 6
) ();
    logic              lookup_en;
    logic [PC_W-1:0]   lookup_pc;
    logic              pred_valid;
    logic              pred_taken;
    logic [CNT_W-1:0]  pred_cnt;
    logic [HIST_W-1:0] pred_hist;
    logic              upd_valid;
    logic [PC_W-1:0]   upd_pc;
    logic [HIST_W-1:0] upd_hist;
    logic              upd_taken;

    modport master (
        output lookup_en, lookup_pc,
        output upd_valid, upd_pc, upd_hist, upd_taken,
        input  pred_valid, pred_taken, pred_cnt, pred_hist
    );

    modport slave (
        input  lookup_en, lookup_pc,
        input  upd_valid, upd_pc, upd_hist, upd_taken,
        output pred_valid, pred_taken, pred_cnt, pred_hist
    );
endinterface

`default_nettype wire

// File: rtl/bp_counter_table.sv
// ============================================================================
//  Module      : bp_counter_table
//  Description : Pattern-history table of 2**IDX_W saturating counters of
//                CNT_W bits. A lookup returns the registered prediction one
//                cycle later; resolved branches train the indexed counter.
//                Same-cycle lookup and update of one entry is write-first.
//  Ports       : clk     clock
//                reset   asynchronous active-high reset
//                bus     bp_counter_table_if.slave (lookup / pred / update)
//  Option      : define BP_GSHARE_EN to XOR a global history register into
//                the index (gshare). Without it no history register exists,
//                pred_hist is 0 and upd_hist is ignored.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_counter_table #(
    parameter int PC_W     = 64,
    parameter int IDX_W    = 6,
    parameter int CNT_W    = 2,
    parameter int INIT_CNT = 2**(CNT_W-1),
    parameter int HIST_W   = 6
) (
    input  wire logic          clk,
    input  wire logic          reset,
    bp_counter_table_if.slave  bus
);

    localparam int              ENTRIES  = 2**IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CNT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q [ENTRIES];

    // ------------------------------------------------------------------
    // Index generation
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_lkp_base;
    logic [IDX_W-1:0] w_upd_base;
    logic [IDX_W-1:0] w_lkp_idx;
    logic [IDX_W-1:0] w_upd_idx;

    // Word-aligned PCs: the two low bits never distinguish branches.
    assign w_lkp_base = bus.lookup_pc[IDX_W+1:2];
    assign w_upd_base = bus.upd_pc[IDX_W+1:2];

`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0] ghr_q;
    logic [HIST_W-1:0] ghr_d;

    // Lookups hash with the live history; updates hash with the history
    // that travelled with the branch so training hits the entry that made
    // the prediction.
    assign w_lkp_idx = w_lkp_base ^ IDX_W'(ghr_q);
    assign w_upd_idx = w_upd_base ^ IDX_W'(bus.upd_hist);

    // Shift the outcome in at the LSB; the cast drops the oldest bit.
    assign ghr_d = HIST_W'({ghr_q, bus.upd_taken});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_q <= '0;
        end else if (bus.upd_valid) begin
            ghr_q <= ghr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pred_hist <= '0;
        end else if (bus.lookup_en) begin
            bus.pred_hist <= ghr_q;
        end
    end

    logic w_unused;
    assign w_unused = ^{bus.lookup_pc[PC_W-1:IDX_W+2], bus.lookup_pc[1:0],
                        bus.upd_pc[PC_W-1:IDX_W+2],    bus.upd_pc[1:0]};
`else
    assign w_lkp_idx     = w_lkp_base;
    assign w_upd_idx     = w_upd_base;
    assign bus.pred_hist = '0;

    logic w_unused;
    assign w_unused = ^{bus.lookup_pc[PC_W-1:IDX_W+2], bus.lookup_pc[1:0],
                        bus.upd_pc[PC_W-1:IDX_W+2],    bus.upd_pc[1:0],
                        bus.upd_hist};
`endif

    // ------------------------------------------------------------------
    // Saturating next value of the entry being trained
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_upd_cur;
    logic [CNT_W-1:0] w_upd_cnt;

    always_comb begin
        w_upd_cur = cnt_q[w_upd_idx];
        w_upd_cnt = w_upd_cur;
        if (bus.upd_taken) begin
            if (w_upd_cur != CNT_MAX) begin
                w_upd_cnt = w_upd_cur + CNT_W'(1);
            end
        end else begin
            if (w_upd_cur != '0) begin
                w_upd_cnt = w_upd_cur - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Lookup read with write-first bypass from a same-entry update
    // ------------------------------------------------------------------
    logic             w_bypass;
    logic [CNT_W-1:0] w_lkp_cnt;

    assign w_bypass  = bus.upd_valid && (w_upd_idx == w_lkp_idx);
    assign w_lkp_cnt = w_bypass ? w_upd_cnt : cnt_q[w_lkp_idx];

    // ------------------------------------------------------------------
    // Counter array
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (bus.upd_valid) begin
            cnt_q[w_upd_idx] <= w_upd_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Registered prediction; pred_cnt/pred_taken hold between lookups
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.pred_valid <= 1'b0;
            bus.pred_taken <= 1'b0;
            bus.pred_cnt   <= '0;
        end else begin
            bus.pred_valid <= bus.lookup_en;
            if (bus.lookup_en) begin
                bus.pred_cnt   <= w_lkp_cnt;
                bus.pred_taken <= w_lkp_cnt[CNT_W-1];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bp_counter_table.sv
// ============================================================================
//  Module      : tb_bp_counter_table
//  Description : Directed self-checking bench for bp_counter_table with
//                hand-computed expected counter values.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bp_counter_table;

    localparam int PC_W   = 64;
    localparam int IDX_W  = 6;
    localparam int CNT_W  = 2;
    localparam int HIST_W = 6;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    bp_counter_table_if #(.PC_W(PC_W), .CNT_W(CNT_W), .HIST_W(HIST_W)) bus_if ();

    bp_counter_table #(
        .PC_W   (PC_W),
        .IDX_W  (IDX_W),
        .CNT_W  (CNT_W),
        .HIST_W (HIST_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus_if.lookup_en = 1'b0;
        bus_if.upd_valid = 1'b0;
    endtask

    task automatic lookup(input logic [63:0] pc);
        bus_if.lookup_en = 1'b1;
        bus_if.lookup_pc = pc;
        bus_if.upd_valid = 1'b0;
        step();
        bus_if.lookup_en = 1'b0;
    endtask

    task automatic update(input logic [63:0] pc, input logic tk, input logic [HIST_W-1:0] h);
        bus_if.lookup_en = 1'b0;
        bus_if.upd_valid = 1'b1;
        bus_if.upd_pc    = pc;
        bus_if.upd_taken = tk;
        bus_if.upd_hist  = h;
        step();
        bus_if.upd_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus_if.lookup_en = 1'b0;
        bus_if.lookup_pc = '0;
        bus_if.upd_valid = 1'b0;
        bus_if.upd_pc    = '0;
        bus_if.upd_hist  = '0;
        bus_if.upd_taken = 1'b0;

        step();
        step();
        check("rst_valid", bus_if.pred_valid, 0);
        check("rst_taken", bus_if.pred_taken, 0);
        check("rst_cnt",   bus_if.pred_cnt,   0);
        check("rst_hist",  bus_if.pred_hist,  0);
        reset = 1'b0;

`ifndef BP_GSHARE_EN
        // Fresh entry is weakly taken.
        lookup(64'h8000_0010);
        check("init_valid", bus_if.pred_valid, 1);
        check("init_cnt",   bus_if.pred_cnt,   2);
        check("init_taken", bus_if.pred_taken, 1);
        check("init_hist",  bus_if.pred_hist,  0);
        step();
        check("idle_valid", bus_if.pred_valid, 0);
        check("idle_hold",  bus_if.pred_cnt,   2);

        // Back-to-back not-taken updates, then underflow attempt.
        bus_if.upd_valid = 1'b1;
        bus_if.upd_pc    = 64'h8000_0010;
        bus_if.upd_taken = 1'b0;
        bus_if.upd_hist  = 6'h3f;
        step();
        step();
        step();
        idle();
        lookup(64'h8000_0010);
        check("nt3_cnt",   bus_if.pred_cnt,   0);
        check("nt3_taken", bus_if.pred_taken, 0);
        update(64'h8000_0010, 1'b0, '0);
        lookup(64'h8000_0010);
        check("nt_floor",  bus_if.pred_cnt,   0);

        // Saturate at the top.
        for (int i = 0; i < 5; i++) update(64'h8000_0020, 1'b1, '0);
        lookup(64'h8000_0020);
        check("t5_cnt",    bus_if.pred_cnt,   3);
        check("t5_taken",  bus_if.pred_taken, 1);
        lookup(64'h8000_0120);
        check("alias_cnt", bus_if.pred_cnt,   3);

        // Same-cycle lookup + update on one entry: write-first.
        bus_if.lookup_en = 1'b1;
        bus_if.lookup_pc = 64'h8000_0030;
        bus_if.upd_valid = 1'b1;
        bus_if.upd_pc    = 64'h8000_0030;
        bus_if.upd_taken = 1'b0;
        step();
        idle();
        check("wf_cnt",   bus_if.pred_cnt,   1);
        check("wf_taken", bus_if.pred_taken, 0);

        // Same-cycle lookup + update on different entries.
        bus_if.lookup_en = 1'b1;
        bus_if.lookup_pc = 64'h8000_0010;
        bus_if.upd_valid = 1'b1;
        bus_if.upd_pc    = 64'h8000_0030;
        bus_if.upd_taken = 1'b1;
        step();
        idle();
        check("indep_cnt", bus_if.pred_cnt, 0);
        lookup(64'h8000_0030);
        check("indep_upd", bus_if.pred_cnt, 2);

        // Asynchronous reset mid-prediction.
        bus_if.lookup_en = 1'b1;
        bus_if.lookup_pc = 64'h8000_0020;
        step();
        check("pre_rst_valid", bus_if.pred_valid, 1);
        #2;
        bus_if.lookup_en = 1'b0;
        reset = 1'b1;
        #1;
        check("async_rst_valid", bus_if.pred_valid, 0);
        check("async_rst_cnt",   bus_if.pred_cnt,   0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_valid", bus_if.pred_valid, 0);
        lookup(64'h8000_0020);
        check("post_rst_cnt", bus_if.pred_cnt, 2);
`else
        // History build-up: taken, taken, not-taken -> 6'b000110.
        update(64'h8000_0040, 1'b1, 6'd0);
        update(64'h8000_0040, 1'b1, 6'd0);
        update(64'h8000_0040, 1'b0, 6'd0);
        // Base 0 XOR history 6 -> entry 6, untouched.
        lookup(64'h8000_0000);
        check("gs_valid", bus_if.pred_valid, 1);
        check("gs_hist",  bus_if.pred_hist,  6);
        check("gs_cnt6",  bus_if.pred_cnt,   2);
        // Entry 16 went 2->3->3->2; GHR=6 so base 22 reaches it.
        lookup(64'h8000_0058);
        check("gs_cnt16", bus_if.pred_cnt, 2);
        // Train entry 6 (base 0 XOR carried history 6); GHR -> 6'b001101.
        update(64'h8000_0000, 1'b1, 6'd6);
        lookup(64'h8000_002C);
        check("gs_hist2", bus_if.pred_hist, 13);
        check("gs_e6",    bus_if.pred_cnt,  3);
        lookup(64'h8000_0034);
        check("gs_e0",    bus_if.pred_cnt,  2);
        step();
        check("gs_idle_valid", bus_if.pred_valid, 0);
        check("gs_hold_hist",  bus_if.pred_hist,  13);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
